// File: rtl/mix_if.sv
// Control, seed and readout signals of the mix sequencer, grouped so that a
// driver and the sequencer can be connected with a single port.
//
// Handshake: start is a level-sampled request. It is accepted only on an edge
// where busy=0. busy stays high from the first op cycle through the cycle that
// shows done. done is a one-cycle pulse and carries no ready. seed_we is
// accepted only while busy=0. rd_data is a combinational read of lane rd_idx.
interface mix_if;
    logic        start;
    logic        abort;
    logic        seed_we;
    logic [2:0]  seed_idx;
    logic [31:0] seed_data;
    logic [2:0]  rd_idx;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output abort,
        output seed_we,
        output seed_idx,
        output seed_data,
        output rd_idx,
        input  rd_data,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  abort,
        input  seed_we,
        input  seed_idx,
        input  seed_data,
        input  rd_idx,
        output rd_data,
        output busy,
        output done
    );
endinterface

// File: rtl/mix_sequencer.sv
// Eight-lane 32-bit mixing engine. Each clock in an op state applies one full
// round to all lanes. The program is (ADD, CHAIN) x ROUNDS, then
// FOLD x FOLDS, then MUL x ROUNDS, then a single DONE cycle.
// The current state is exported on dbg_state.
module mix_sequencer #(
    parameter int ROUNDS = 6,
    parameter int FOLDS  = 12
) (
    input  logic       clk,
    input  logic       rst,
    mix_if.slave       bus,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADD   = 3'd1;
    localparam logic [2:0] S_CHAIN = 3'd2;
    localparam logic [2:0] S_FOLD  = 3'd3;
    localparam logic [2:0] S_MUL   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Last counter value of a phase. When FOLDS is 0 the FOLD phase is never
    // entered, so its wrapped terminal value is never compared against.
    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);
    localparam logic [7:0] LAST_FOLD  = 8'(FOLDS - 1);

    localparam logic [31:0] K_TAB [8] = '{32'd2, 32'd3, 32'd5, 32'd7,
                                          32'd11, 32'd13, 32'd17, 32'd19};
    localparam logic [31:0] C_TAB [8] = '{32'd3, 32'd5, 32'd7, 32'd11,
                                          32'd13, 32'd17, 32'd19, 32'd23};

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [7:0]        round_cnt;
    logic [7:0]        round_cnt_next;
    logic [7:0][31:0]  lanes;
    logic [7:0][31:0]  lanes_next;
    logic              busy_int;
    logic              abort_hit;

    assign busy_int  = (state != S_IDLE);
    assign abort_hit = busy_int && bus.abort;

    assign bus.busy    = busy_int;
    assign bus.done    = (state == S_DONE);
    assign bus.rd_data = lanes[bus.rd_idx];
    assign dbg_state   = state;

    // Phase sequencing. The round counter counts ADD/CHAIN pairs, FOLD rounds
    // and MUL rounds, and clears whenever the program moves to a new phase.
    always_comb begin
        state_next     = state;
        round_cnt_next = round_cnt;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next     = S_ADD;
                    round_cnt_next = 8'd0;
                end
            end
            S_ADD: begin
                state_next = S_CHAIN;
            end
            S_CHAIN: begin
                if (round_cnt == LAST_ROUND) begin
                    state_next     = (FOLDS == 0) ? S_MUL : S_FOLD;
                    round_cnt_next = 8'd0;
                end else begin
                    state_next     = S_ADD;
                    round_cnt_next = round_cnt + 8'd1;
                end
            end
            S_FOLD: begin
                if (round_cnt == LAST_FOLD) begin
                    state_next     = S_MUL;
                    round_cnt_next = 8'd0;
                end else begin
                    round_cnt_next = round_cnt + 8'd1;
                end
            end
            S_MUL: begin
                if (round_cnt == LAST_ROUND) begin
                    state_next     = S_DONE;
                    round_cnt_next = 8'd0;
                end else begin
                    round_cnt_next = round_cnt + 8'd1;
                end
            end
            S_DONE: begin
                state_next     = S_IDLE;
                round_cnt_next = 8'd0;
            end
            default: begin
                state_next     = S_IDLE;
                round_cnt_next = 8'd0;
            end
        endcase
        // Abort wins over whatever the current state would do next.
        if (abort_hit) begin
            state_next     = S_IDLE;
            round_cnt_next = 8'd0;
        end
    end

    // Lane datapath. CHAIN and FOLD walk the lanes in index order and read
    // the values already updated earlier in the same round.
    always_comb begin
        lanes_next = lanes;
        case (state)
            S_IDLE: begin
                if (bus.seed_we) begin
                    lanes_next[bus.seed_idx] = bus.seed_data;
                end
            end
            S_ADD: begin
                for (int i = 0; i < 8; i++) begin
                    lanes_next[i] = lanes[i] + 32'(i);
                end
            end
            S_CHAIN: begin
                lanes_next[0] = lanes[0] + lanes[7];
                for (int i = 1; i < 8; i++) begin
                    lanes_next[i] = lanes[i] + lanes_next[i-1];
                end
            end
            S_FOLD: begin
                for (int i = 0; i < 8; i++) begin
                    lanes_next[i] = lanes_next[i] + lanes_next[(i + 7) % 8]
                                    - lanes_next[(i + 6) % 8];
                end
            end
            S_MUL: begin
                for (int i = 0; i < 8; i++) begin
                    lanes_next[i] = lanes[i] * K_TAB[i] + C_TAB[i];
                end
            end
            default: begin
                lanes_next = lanes;
            end
        endcase
        // An aborted cycle leaves the partial lane values untouched.
        if (abort_hit) begin
            lanes_next = lanes;
        end
    end

    // State, counter and lane registers. Reset restores lanes to their index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            round_cnt <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                lanes[i] <= 32'(i);
            end
        end else begin
            state     <= state_next;
            round_cnt <= round_cnt_next;
            lanes     <= lanes_next;
        end
    end

endmodule

// File: doc/mix_sequencer.md
MIX_SEQUENCER -- requirements
Module: mix_sequencer

Interface
REQ-001 Parameter ROUNDS, default 6: number of ADD/CHAIN round pairs and of MUL rounds; legal range 1..255.
REQ-002 Parameter FOLDS, default 12: number of FOLD rounds; legal range 0..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to run one full program on the current lane values.
REQ-006 abort  input  1  terminate a running program.
REQ-007 seed_we  input  1  write seed_data into lane seed_idx.
REQ-008 seed_idx  input  3  lane select for seed writes.
REQ-009 seed_data  input  32  seed value.
REQ-010 rd_idx  input  3  lane select for readout.
REQ-011 rd_data  output  32  combinational read of lane rd_idx.
REQ-012 busy  output  1  program in progress, including the DONE cycle.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 Block holds eight 32-bit lanes o0..o7; all arithmetic is modulo 2^32 and unsigned.
REQ-015 States: IDLE, ADD, CHAIN, FOLD, MUL, DONE; exactly one lane operation is applied per clock in ADD/CHAIN/FOLD/MUL.
REQ-016 ADD: oi = oi + i for i = 0..7.
REQ-017 CHAIN: lanes updated in order i = 0..7 using already-updated values: o0 = o0 + o7, then oi = oi + o(i-1).
REQ-018 FOLD: lanes updated in order i = 0..7 using already-updated values: oi = oi + o((i-1) mod 8) - o((i-2) mod 8).
REQ-019 MUL: oi = oi*K[i] + C[i], with K = {2,3,5,7,11,13,17,19} and C = {3,5,7,11,13,17,19,23}; lanes are independent.
REQ-020 Program order: (ADD, CHAIN) x ROUNDS, then FOLD x FOLDS (skipped when 0), then MUL x ROUNDS, then DONE.
REQ-021 An 8-bit round counter sequences the phases; it clears on every phase change.
REQ-022 IDLE with start=1 at edge k: next state ADD; the op edges are k+1 .. k+3*ROUNDS+FOLDS.
REQ-023 DONE: done=1 and busy=1 for exactly one cycle, then IDLE; done is observed 3*ROUNDS+FOLDS cycles after edge k (30 with defaults).
REQ-024 busy=1 in every state except IDLE.
REQ-025 start while busy=1 (including DONE) is ignored; there is no queuing.
REQ-026 seed_we in IDLE writes the lane at that edge; seed_we while busy=1 is ignored.
REQ-027 seed_we and start in the same IDLE cycle: the seed write takes effect and the program starts on the updated lanes at the next edge.
REQ-028 abort while busy=1: next state IDLE and no done; lanes hold their partial values, and the op of the abort cycle is not applied.
REQ-029 abort in IDLE has no effect; abort has priority over the state's op.

Reset
REQ-030 rst=1 at an edge, in any state and with priority over all other inputs: state IDLE, round counter 0, oi = i, busy=0, done=0.
REQ-031 Reset mid-program discards the run; no done is produced.

Verification
REQ-032 Reset, then sweep rd_idx 0..7 -> rd_data = 0..7, busy=0, done=0.
REQ-033 ROUNDS=1, FOLDS=0, reset seeds, pulse start -> done 3 cycles later; lanes = 31, 53, 107, 193, 387, 589, 971, 1353.
REQ-034 Same configuration; start and seed_we (lane 0 = 0xFFFFFFFF) asserted in the cycle after the program starts -> both ignored; result identical to REQ-033, and exactly one done pulse.
REQ-035 ROUNDS=1, FOLDS=0; start, then abort in the CHAIN cycle -> busy=0 at the next edge, no done; lanes = 0, 2, 4, 6, 8, 10, 12, 14.
REQ-036 Defaults; rst asserted at cycle 15 of a run -> lanes = 0..7, busy=0, no done; a subsequent start completes normally in 30 cycles.
REQ-037 Defaults; 1000 random seed sets, including 0xFFFFFFFF lanes -> every lane matches the reference model bit-exactly, with 30-cycle latency and a single done pulse per run.
